game_sequencer: RTL and testbench

//  Parametrised game-control core for the Pacman top level. It generates the game tick (generalised timer1ms)
//  and debounces NUM_BTN buttons. It also latches Pacman direction, detects Pacman/monster collisions for NUM_MON

---
 rtl/game_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_game_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game-control core: tick divider, button debounce, direction latch, collision check,
// IDLE/PLAY/DYING/OVER sequencer with lives and saturating score.
module game_sequencer #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned DEB_TICKS   = 8,
  parameter int unsigned NUM_MON     = 3,
  parameter int unsigned POS_W       = 9,
  parameter int unsigned HIT_DIST    = 8,
  parameter int unsigned LIVES       = 3,
  parameter int unsigned DEATH_TICKS = 1000,
  parameter int unsigned SCORE_W     = 16,
  parameter int unsigned DOT_PTS     = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_BTN-1:0]         btn,
  input  logic [POS_W-1:0]           p_x,
  input  logic [POS_W-1:0]           p_y,
  input  logic [NUM_MON*POS_W-1:0]   m_x,
  input  logic [NUM_MON*POS_W-1:0]   m_y,
  input  logic                       dot_eaten,
  output logic                       tick,
  output logic [NUM_BTN-1:0]         btn_press,
  output logic [1:0]                 dir,
  output logic [1:0]                 state,
  output logic                       freeze,
  output logic                       respawn,
  output logic [2:0]                 lives,
  output logic [SCORE_W-1:0]         score
);

  localparam int unsigned TW  = $clog2(TICK_DIV);
  localparam int unsigned DW  = $clog2(DEB_TICKS + 1);
  localparam int unsigned KW  = $clog2(DEATH_TICKS + 1);
  localparam int unsigned SW1 = SCORE_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DYING = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 tick_q, tick_d;
  logic [NUM_BTN-1:0]   sync1_q, sync2_q;
  logic [NUM_BTN-1:0]   deb_q, deb_d;
  logic [NUM_BTN-1:0]   arm_q, arm_d;
  logic [NUM_BTN-1:0]   press_q, press_d;
  logic [DW-1:0]        dbc_q [NUM_BTN];
  logic [DW-1:0]        dbc_d [NUM_BTN];
  logic [1:0]           dir_q, dir_d;
  logic [KW-1:0]        dcnt_q, dcnt_d;
  logic [2:0]           lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 respawn_q, respawn_d;
  logic                 hit;
  logic                 any_press;
  logic [SCORE_W:0]     sum;

  function automatic logic [POS_W-1:0] absdiff(input logic [POS_W-1:0] a, input logic [POS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    if (tcnt_q == TW'(TICK_DIV - 1)) begin
      tcnt_d = '0;
      tick_d = 1'b1;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
      tick_d = 1'b0;
    end
  end

  // arm_q blocks a press for a button that was already held when reset was released:
  // it only sets once the synchronised level has been seen low on a tick.
  always_comb begin
    deb_d   = deb_q;
    arm_d   = arm_q;
    press_d = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      dbc_d[i] = dbc_q[i];
      if (tick_q) begin
        if (!sync2_q[i]) arm_d[i] = 1'b1;
        if (sync2_q[i] == deb_q[i]) begin
          dbc_d[i] = '0;
        end else if (dbc_q[i] == DW'(DEB_TICKS - 1)) begin
          dbc_d[i]   = '0;
          deb_d[i]   = sync2_q[i];
          press_d[i] = sync2_q[i] & arm_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    dir_d = dir_q;
    if (state_q == S_PLAY) begin
      for (int unsigned j = 0; j < NUM_BTN; j++) begin
        if (press_q[NUM_BTN-1-j]) dir_d = 2'(NUM_BTN - 1 - j);
      end
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_MON; i++) begin
      if (absdiff(p_x, m_x[i*POS_W +: POS_W]) < POS_W'(HIT_DIST) &&
          absdiff(p_y, m_y[i*POS_W +: POS_W]) < POS_W'(HIT_DIST)) hit = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    dcnt_d    = dcnt_q;
    respawn_d = 1'b0;
    any_press = |press_q;
    sum       = {1'b0, score_q} + SW1'(DOT_PTS);
    case (state_q)
      S_IDLE: begin
        if (any_press) begin
          state_d   = S_PLAY;
          lives_d   = 3'(LIVES);
          score_d   = '0;
          respawn_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (dot_eaten) score_d = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
        if (tick_q && hit) begin
          state_d = S_DYING;
          lives_d = lives_q - 3'd1;
          dcnt_d  = '0;
        end
      end
      S_DYING: begin
        if (tick_q) begin
          if (dcnt_q == KW'(DEATH_TICKS - 1)) begin
            dcnt_d = '0;
            if (lives_q == 3'd0) begin
              state_d = S_OVER;
            end else begin
              state_d   = S_PLAY;
              respawn_d = 1'b1;
            end
          end else begin
            dcnt_d = dcnt_q + KW'(1);
          end
        end
      end
      S_OVER: begin
        if (any_press) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      tcnt_q    <= '0;
      tick_q    <= 1'b0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      arm_q     <= '0;
      press_q   <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) dbc_q[i] <= '0;
      dir_q     <= '0;
      dcnt_q    <= '0;
      lives_q   <= 3'(LIVES);
      score_q   <= '0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      tick_q    <= tick_d;
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      arm_q     <= arm_d;
      press_q   <= press_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) dbc_q[i] <= dbc_d[i];
      dir_q     <= dir_d;
      dcnt_q    <= dcnt_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      respawn_q <= respawn_d;
    end
  end

  assign tick      = tick_q;
  assign btn_press = press_q;
  assign dir       = dir_q;
  assign state     = state_q;
  assign freeze    = (state_q != S_PLAY);
  assign respawn   = respawn_q;
  assign lives     = lives_q;
  assign score     = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: tick timing, debounce, and a table-driven game flow.
module tb_game_sequencer;

  localparam int POS_W = 9;
  localparam int NMON  = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [3:0]            btn;
  logic [POS_W-1:0]      p_x, p_y;
  logic [NMON*POS_W-1:0] m_x, m_y;
  logic                  dot;
  logic                  tick;
  logic [3:0]            btn_press;
  logic [1:0]            dir;
  logic [1:0]            state;
  logic                  freeze;
  logic                  respawn;
  logic [2:0]            lives;
  logic [7:0]            score;

  game_sequencer #(
    .TICK_DIV(4), .NUM_BTN(4), .DEB_TICKS(2), .NUM_MON(NMON), .POS_W(POS_W),
    .HIT_DIST(8), .LIVES(2), .DEATH_TICKS(3), .SCORE_W(8), .DOT_PTS(10)
  ) dut (
    .clk(clk), .reset(reset), .btn(btn), .p_x(p_x), .p_y(p_y), .m_x(m_x), .m_y(m_y),
    .dot_eaten(dot), .tick(tick), .btn_press(btn_press), .dir(dir), .state(state),
    .freeze(freeze), .respawn(respawn), .lives(lives), .score(score)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int press2_cnt = 0;

  always @(posedge clk) begin
    #2;
    if (respawn) resp_cnt++;
    if (btn_press[2]) press2_cnt++;
  end

  typedef enum int {OP_PRESS, OP_DOTS, OP_HIT, OP_NOHIT, OP_TICKS} op_t;
  typedef struct {
    op_t op;
    int  arg;
    int  st;
    int  lv;
    int  sc;
    int  dr;
    int  rs;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sync_tick();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!tick && t < 40);
    if (!tick) chk("tick_wait", int'(tick), 1);
  endtask

  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      sync_tick();
      @(negedge clk);
    end
  endtask

  task automatic set_m1(input int x, input int y);
    m_x[POS_W +: POS_W] = POS_W'(x);
    m_y[POS_W +: POS_W] = POS_W'(y);
  endtask

  task automatic press(input logic [3:0] mask);
    bit found = 1'b0;
    btn = mask;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if ((btn_press & mask) != 4'd0) found = 1'b1;
    end
    if (!found) chk("press_wait", int'(|(btn_press & mask)), 1);
    btn = 4'd0;
    wait_ticks(8);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int first_tk, prev_tk, ntk, bad_gap, lat, base2, rbase;
    bit found;

    reset = 1'b0;
    btn   = 4'd0;
    dot   = 1'b0;
    p_x   = 9'd100;
    p_y   = 9'd100;
    m_x   = {3{9'd300}};
    m_y   = {3{9'd300}};
    repeat (3) @(negedge clk);

    chk("rst_tick",    int'(tick), 0);
    chk("rst_press",   int'(btn_press), 0);
    chk("rst_dir",     int'(dir), 0);
    chk("rst_state",   int'(state), 0);
    chk("rst_freeze",  int'(freeze), 1);
    chk("rst_respawn", int'(respawn), 0);
    chk("rst_lives",   int'(lives), 2);
    chk("rst_score",   int'(score), 0);

    // Tick generation over 40 clocks after reset release
    reset = 1'b1;
    first_tk = -1; prev_tk = -1; ntk = 0; bad_gap = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (tick) begin
        ntk++;
        if (first_tk < 0) first_tk = k;
        if (prev_tk >= 0 && k - prev_tk != 4) bad_gap++;
        prev_tk = k;
      end
    end
    chk("tick_count", ntk, 10);
    chk("tick_first", first_tk, 4);
    chk("tick_bad_gaps", bad_gap, 0);

    // One-tick glitch on btn[2]: no press
    base2 = press2_cnt;
    sync_tick();
    btn[2] = 1'b1;
    repeat (4) @(negedge clk);
    btn[2] = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_press", press2_cnt - base2, 0);
    chk("glitch_state", int'(state), 0);

    // Bounce 1-0-1 then hold: exactly one press, fixed latency
    base2 = press2_cnt;
    lat = -1;
    sync_tick();
    btn[2] = 1'b1;
    @(negedge clk);
    btn[2] = 1'b0;
    @(negedge clk);
    btn[2] = 1'b1;
    for (int t = 3; t <= 40; t++) begin
      @(negedge clk);
      if (btn_press[2] && lat < 0) lat = t;
    end
    chk("bounce_press", press2_cnt - base2, 1);
    chk("bounce_latency", lat, 9);
    chk("bounce_state", int'(state), 1);

    // Reset while held: released reset must not produce a press
    reset = 1'b0;
    #1;
    chk("async_rst_state", int'(state), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base2 = press2_cnt;
    repeat (40) @(negedge clk);
    chk("held_rst_press", press2_cnt - base2, 0);
    chk("held_rst_state", int'(state), 0);
    btn[2] = 1'b0;
    wait_ticks(8);
    chk("held_release_press", press2_cnt - base2, 0);

    rbase = resp_cnt;
    //          op        arg st lv  sc  dr rs
    tbl[0]  = '{OP_PRESS,   1, 1, 2,   0, 0, 1};
    tbl[1]  = '{OP_PRESS,   8, 1, 2,   0, 3, 1};
    tbl[2]  = '{OP_PRESS,  10, 1, 2,   0, 1, 1};
    tbl[3]  = '{OP_DOTS,    3, 1, 2,  30, 1, 1};
    tbl[4]  = '{OP_NOHIT,   0, 1, 2,  30, 1, 1};
    tbl[5]  = '{OP_HIT,     0, 2, 1,  30, 1, 1};
    tbl[6]  = '{OP_DOTS,    2, 2, 1,  30, 1, 1};
    tbl[7]  = '{OP_TICKS,   3, 1, 1,  30, 1, 2};
    tbl[8]  = '{OP_DOTS,    1, 1, 1,  40, 1, 2};
    tbl[9]  = '{OP_HIT,     0, 2, 0,  40, 1, 2};
    tbl[10] = '{OP_TICKS,   3, 3, 0,  40, 1, 2};
    tbl[11] = '{OP_PRESS,   4, 0, 0,  40, 1, 2};
    tbl[12] = '{OP_PRESS,   1, 1, 2,   0, 1, 3};
    tbl[13] = '{OP_DOTS,   24, 1, 2, 240, 1, 3};
    tbl[14] = '{OP_DOTS,    1, 1, 2, 250, 1, 3};
    tbl[15] = '{OP_DOTS,    1, 1, 2, 255, 1, 3};
    tbl[16] = '{OP_DOTS,    4, 1, 2, 255, 1, 3};

    for (int i = 0; i < 17; i++) begin
      case (tbl[i].op)
        OP_PRESS: press(4'(tbl[i].arg));
        OP_DOTS: begin
          dot = 1'b1;
          repeat (tbl[i].arg) @(negedge clk);
          dot = 1'b0;
        end
        OP_NOHIT: begin
          set_m1(108, 100);
          wait_ticks(2);
          set_m1(300, 300);
        end
        OP_HIT: begin
          set_m1(107, 93);
          found = 1'b0;
          for (int t = 0; t < 12 && !found; t++) begin
            @(negedge clk);
            if (state == 2'd2) found = 1'b1;
          end
          if (!found) chk("hit_wait", int'(state), 2);
          set_m1(300, 300);
        end
        OP_TICKS: wait_ticks(tbl[i].arg);
        default: ;
      endcase
      chk($sformatf("v%0d_state", i),   int'(state),  tbl[i].st);
      chk($sformatf("v%0d_lives", i),   int'(lives),  tbl[i].lv);
      chk($sformatf("v%0d_score", i),   int'(score),  tbl[i].sc);
      chk($sformatf("v%0d_dir", i),     int'(dir),    tbl[i].dr);
      chk($sformatf("v%0d_freeze", i),  int'(freeze), (tbl[i].st != 1) ? 1 : 0);
      chk($sformatf("v%0d_respawn", i), resp_cnt - rbase, tbl[i].rs);
    end

    // Asynchronous reset in the middle of a game
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_state",  int'(state), 0);
    chk("midrst_score",  int'(score), 0);
    chk("midrst_lives",  int'(lives), 2);
    chk("midrst_freeze", int'(freeze), 1);
    chk("midrst_dir",    int'(dir), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
